// File: rtl/adc_capture_ctrl.sv
// Triggered dual-channel ADC snapshot into a pair of ring buffers, with a programmable
// pre-trigger depth and status that lets firmware unroll the ring after capture.
module adc_capture_ctrl #(
    parameter int unsigned AW = 11,
    parameter int unsigned DW = 12
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          cfg_arm,
    input  logic          cfg_abort,
    input  logic [1:0]    cfg_trig_mode,
    input  logic [DW-1:0] cfg_trig_level,
    input  logic [AW-1:0] cfg_pretrig,
    input  logic          ext_trig,
    input  logic          adc_vld,
    input  logic [DW-1:0] adc_ch0,
    input  logic [DW-1:0] adc_ch1,
    output logic          buf_wr,
    output logic [AW-1:0] buf_addr,
    output logic [DW-1:0] buf_data0,
    output logic [DW-1:0] buf_data1,
    output logic          sts_busy,
    output logic          sts_triggered,
    output logic          sts_done,
    output logic          sts_wrapped,
    output logic [AW-1:0] sts_trig_addr
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned PW    = AW + 1;
    localparam logic [PW-1:0] DepthW = PW'(DEPTH);
    localparam logic [AW-1:0] PtrMax = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StWaitTrig,
        StPost,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [AW-1:0]        ptr_q, ptr_d;
    logic [AW-1:0]        pre_cnt_q, pre_cnt_d;
    logic [PW-1:0]        remaining_q, remaining_d;
    logic [1:0]           mode_q, mode_d;
    logic signed [DW-1:0] level_q, level_d;
    logic [AW-1:0]        pretrig_q, pretrig_d;
    logic signed [DW-1:0] prev_q, prev_d;
    logic                 prev_vld_q, prev_vld_d;
    logic                 ext_prev_q, ext_prev_d;
    logic                 ext_edge_q, ext_edge_d;

    logic                 buf_wr_q, buf_wr_d;
    logic [AW-1:0]        buf_addr_q, buf_addr_d;
    logic [DW-1:0]        buf_data0_q, buf_data0_d;
    logic [DW-1:0]        buf_data1_q, buf_data1_d;
    logic                 triggered_q, triggered_d;
    logic                 done_q, done_d;
    logic                 wrapped_q, wrapped_d;
    logic [AW-1:0]        trig_addr_q, trig_addr_d;

    logic                 busy;
    logic                 ext_rise;
    logic                 trig_hit;
    logic signed [DW-1:0] cur_smp;
    logic [PW-1:0]        post_init;

    assign busy      = (state_q == StPre) || (state_q == StWaitTrig) || (state_q == StPost);
    assign ext_rise  = ext_trig & ~ext_prev_q;
    assign cur_smp   = adc_ch0;
    // Writes still owed after the trigger sample itself.
    assign post_init = DepthW - {1'b0, pretrig_q} - PW'(1);

    always_comb begin
        trig_hit = 1'b0;
        case (mode_q)
            2'd0:    trig_hit = 1'b1;
            2'd1:    trig_hit = prev_vld_q && (prev_q < level_q) && (cur_smp >= level_q);
            2'd2:    trig_hit = prev_vld_q && (prev_q > level_q) && (cur_smp <= level_q);
            2'd3:    trig_hit = ext_edge_q;
            default: trig_hit = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        pre_cnt_d   = pre_cnt_q;
        remaining_d = remaining_q;
        mode_d      = mode_q;
        level_d     = level_q;
        pretrig_d   = pretrig_q;
        prev_d      = prev_q;
        prev_vld_d  = prev_vld_q;
        ext_prev_d  = ext_trig;
        // A pending edge is consumed by the next sample unless a fresh edge arrives with it.
        ext_edge_d  = (ext_edge_q & ~adc_vld) | ext_rise;
        buf_wr_d    = 1'b0;
        buf_addr_d  = buf_addr_q;
        buf_data0_d = buf_data0_q;
        buf_data1_d = buf_data1_q;
        triggered_d = triggered_q;
        done_d      = done_q;
        wrapped_d   = wrapped_q;
        trig_addr_d = trig_addr_q;

        if (cfg_abort) begin
            state_d     = StIdle;
            triggered_d = 1'b0;
            done_d      = 1'b0;
            wrapped_d   = 1'b0;
            trig_addr_d = '0;
        end else if (cfg_arm && !busy) begin
            mode_d      = cfg_trig_mode;
            level_d     = cfg_trig_level;
            pretrig_d   = cfg_pretrig;
            ptr_d       = '0;
            pre_cnt_d   = '0;
            remaining_d = '0;
            prev_d      = '0;
            prev_vld_d  = 1'b0;
            ext_edge_d  = 1'b0;
            triggered_d = 1'b0;
            done_d      = 1'b0;
            wrapped_d   = 1'b0;
            trig_addr_d = '0;
            state_d     = (cfg_pretrig == '0) ? StWaitTrig : StPre;
        end else if (busy && adc_vld) begin
            buf_wr_d    = 1'b1;
            buf_addr_d  = ptr_q;
            buf_data0_d = adc_ch0;
            buf_data1_d = adc_ch1;
            ptr_d       = ptr_q + AW'(1);
            prev_d      = cur_smp;
            prev_vld_d  = 1'b1;
            if ((state_q != StPost) && (ptr_q == PtrMax)) begin
                wrapped_d = 1'b1;
            end
            case (state_q)
                StPre: begin
                    pre_cnt_d = pre_cnt_q + AW'(1);
                    if (pre_cnt_q == pretrig_q - AW'(1)) begin
                        state_d = StWaitTrig;
                    end
                end
                StWaitTrig: begin
                    if (trig_hit) begin
                        triggered_d = 1'b1;
                        trig_addr_d = ptr_q;
                        if (post_init == '0) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end else begin
                            state_d     = StPost;
                            remaining_d = post_init;
                        end
                    end
                end
                StPost: begin
                    if (remaining_q == PW'(1)) begin
                        state_d     = StDone;
                        done_d      = 1'b1;
                        remaining_d = '0;
                    end else begin
                        remaining_d = remaining_q - PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            pre_cnt_q   <= '0;
            remaining_q <= '0;
            mode_q      <= '0;
            level_q     <= '0;
            pretrig_q   <= '0;
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
            ext_prev_q  <= 1'b0;
            ext_edge_q  <= 1'b0;
            buf_wr_q    <= 1'b0;
            buf_addr_q  <= '0;
            buf_data0_q <= '0;
            buf_data1_q <= '0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
            wrapped_q   <= 1'b0;
            trig_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            pre_cnt_q   <= pre_cnt_d;
            remaining_q <= remaining_d;
            mode_q      <= mode_d;
            level_q     <= level_d;
            pretrig_q   <= pretrig_d;
            prev_q      <= prev_d;
            prev_vld_q  <= prev_vld_d;
            ext_prev_q  <= ext_prev_d;
            ext_edge_q  <= ext_edge_d;
            buf_wr_q    <= buf_wr_d;
            buf_addr_q  <= buf_addr_d;
            buf_data0_q <= buf_data0_d;
            buf_data1_q <= buf_data1_d;
            triggered_q <= triggered_d;
            done_q      <= done_d;
            wrapped_q   <= wrapped_d;
            trig_addr_q <= trig_addr_d;
        end
    end

    assign buf_wr        = buf_wr_q;
    assign buf_addr      = buf_addr_q;
    assign buf_data0     = buf_data0_q;
    assign buf_data1     = buf_data1_q;
    assign sts_busy      = busy;
    assign sts_triggered = triggered_q;
    assign sts_done      = done_q;
    assign sts_wrapped   = wrapped_q;
    assign sts_trig_addr = trig_addr_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scoreboard bench for adc_capture_ctrl: a sample-index model predicts every buffer write
// and the final status; a monitor pops and compares each write the DUT presents.
module tb_adc_capture_ctrl;

    localparam int AW    = 11;
    localparam int DW    = 12;
    localparam int DEPTH = 2 ** AW;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          cfg_arm, cfg_abort;
    logic [1:0]    cfg_trig_mode;
    logic [DW-1:0] cfg_trig_level;
    logic [AW-1:0] cfg_pretrig;
    logic          ext_trig, adc_vld;
    logic [DW-1:0] adc_ch0, adc_ch1;
    logic          buf_wr;
    logic [AW-1:0] buf_addr;
    logic [DW-1:0] buf_data0, buf_data1;
    logic          sts_busy, sts_triggered, sts_done, sts_wrapped;
    logic [AW-1:0] sts_trig_addr;

    adc_capture_ctrl #(.AW(AW), .DW(DW)) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .cfg_arm       (cfg_arm),
        .cfg_abort     (cfg_abort),
        .cfg_trig_mode (cfg_trig_mode),
        .cfg_trig_level(cfg_trig_level),
        .cfg_pretrig   (cfg_pretrig),
        .ext_trig      (ext_trig),
        .adc_vld       (adc_vld),
        .adc_ch0       (adc_ch0),
        .adc_ch1       (adc_ch1),
        .buf_wr        (buf_wr),
        .buf_addr      (buf_addr),
        .buf_data0     (buf_data0),
        .buf_data1     (buf_data1),
        .sts_busy      (sts_busy),
        .sts_triggered (sts_triggered),
        .sts_done      (sts_done),
        .sts_wrapped   (sts_wrapped),
        .sts_trig_addr (sts_trig_addr)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        bit            last;
        bit            trig;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_tests = 0;
    int  n_fail  = 0;
    int  wr_cnt  = 0;
    int  last_wr_addr = 0;

    // Stimulus for one capture: per-sample data, ext pulse before the sample, idle gap before it.
    logic signed [DW-1:0] s0[$];
    logic [DW-1:0]        s1[$];
    bit                   pl[$];
    int                   gp[$];

    always @(negedge sys_clk) begin
        if (buf_wr) begin
            n_tests++;
            wr_cnt++;
            last_wr_addr = int'(buf_addr);
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got write addr=%0d, expected no write", buf_addr);
            end else begin
                mon_e = exp_q.pop_front();
                if (buf_addr !== mon_e.addr || buf_data0 !== mon_e.d0 || buf_data1 !== mon_e.d1 ||
                    sts_done !== mon_e.last || sts_triggered !== mon_e.trig) begin
                    n_fail++;
                    $display("FAIL write: got addr=%0d d0=%h d1=%h done=%0b trig=%0b, expected addr=%0d d0=%h d1=%h done=%0b trig=%0b",
                             buf_addr, buf_data0, buf_data1, sts_done, sts_triggered,
                             mon_e.addr, mon_e.d0, mon_e.d1, mon_e.last, mon_e.trig);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input bit vld, input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                         input bit ext, input bit arm, input bit abort, input bit rst);
        adc_vld = vld; adc_ch0 = c0; adc_ch1 = c1; ext_trig = ext;
        cfg_arm = arm; cfg_abort = abort; sys_rst = rst;
        @(posedge sys_clk);
        #1;
        adc_vld = 1'b0; ext_trig = 1'b0; cfg_arm = 1'b0; cfg_abort = 1'b0; sys_rst = 1'b0;
    endtask

    task automatic gen_clear();
        s0.delete(); s1.delete(); pl.delete(); gp.delete();
    endtask

    task automatic gen_push(input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                            input bit pulse, input int gap);
        s0.push_back(c0); s1.push_back(c1); pl.push_back(pulse);
        gp.push_back((pulse && gap == 0) ? 1 : gap);
    endtask

    task automatic chk_all_zero(input string nm, input bit with_data);
        chk({nm, "_buf_wr"}, 32'(buf_wr), 0);
        chk({nm, "_busy"}, 32'(sts_busy), 0);
        chk({nm, "_triggered"}, 32'(sts_triggered), 0);
        chk({nm, "_done"}, 32'(sts_done), 0);
        chk({nm, "_wrapped"}, 32'(sts_wrapped), 0);
        chk({nm, "_trig_addr"}, 32'(sts_trig_addr), 0);
        if (with_data) begin
            chk({nm, "_buf_addr"}, 32'(buf_addr), 0);
            chk({nm, "_buf_data0"}, 32'(buf_data0), 0);
            chk({nm, "_buf_data1"}, 32'(buf_data1), 0);
        end
    endtask

    // Model: sample i (counted from arm) lands at address i mod DEPTH; trigger is the first
    // sample at index >= pretrig meeting the mode rule; DEPTH - pretrig writes from it on.
    task automatic run_capture(input string nm, input logic [1:0] mode,
                               input logic signed [DW-1:0] lvl, input int p,
                               input int stop_at, input bit end_rst, input int arm_mid);
        int t, nwr, nd;
        bit hit;
        wr_t w;
        t = -1;
        for (int i = p; i < s0.size(); i++) begin
            case (mode)
                2'd0:    hit = 1'b1;
                2'd1:    hit = (i > 0) && (s0[i-1] < lvl) && (s0[i] >= lvl);
                2'd2:    hit = (i > 0) && (s0[i-1] > lvl) && (s0[i] <= lvl);
                default: hit = pl[i];
            endcase
            if (hit) begin
                t = i;
                break;
            end
        end
        nwr = (t < 0) ? s0.size() : t + DEPTH - p;
        while (t >= 0 && s0.size() < nwr + 3) gen_push(DW'($urandom), DW'($urandom), 1'b0, 0);

        cfg_trig_mode = mode; cfg_trig_level = lvl; cfg_pretrig = AW'(p);
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        wr_cnt = 0;
        cfg_trig_mode = 2'($urandom); cfg_trig_level = DW'($urandom); cfg_pretrig = AW'($urandom);

        nd = (stop_at >= 0) ? stop_at + 1 : s0.size();
        for (int i = 0; i < nd; i++) begin
            if (i == arm_mid) begin
                cfg_trig_mode = 2'd0; cfg_pretrig = '0;
                drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
            end
            for (int g = 0; g < gp[i]; g++) drive(1'b0, '0, '0, (g == 0) && pl[i], 1'b0, 1'b0, 1'b0);
            if (i < nwr) begin
                w.addr = AW'(i % DEPTH); w.d0 = s0[i]; w.d1 = s1[i];
                w.last = (t >= 0) && (i == nwr - 1);
                w.trig = (t >= 0) && (i >= t);
                exp_q.push_back(w);
            end
            drive(1'b1, s0[i], s1[i], 1'b0, 1'b0, 1'b0, 1'b0);
        end

        if (stop_at < 0 && t >= 0) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk({nm, "_done"}, 32'(sts_done), 1);
            chk({nm, "_triggered"}, 32'(sts_triggered), 1);
            chk({nm, "_trig_addr"}, 32'(sts_trig_addr), 32'(t % DEPTH));
            chk({nm, "_wrapped"}, 32'(sts_wrapped), 32'(t >= DEPTH - 1));
            chk({nm, "_busy"}, 32'(sts_busy), 0);
            chk({nm, "_idle_wr"}, 32'(buf_wr), 0);
            chk({nm, "_writes"}, 32'(wr_cnt), 32'(nwr));
        end else begin
            chk({nm, "_busy_before_stop"}, 32'(sts_busy), 1);
            chk({nm, "_trig_before_stop"}, 32'(sts_triggered), 32'(t >= 0 && t < nd));
            if (end_rst) drive(1'b1, DW'($urandom), DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
            else drive(1'b1, DW'($urandom), DW'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
            chk_all_zero({nm, "_stopped"}, end_rst);
        end
        chk({nm, "_queue_drained"}, 32'(exp_q.size()), 0);
    endtask

    initial begin
        cfg_trig_mode = '0; cfg_trig_level = '0; cfg_pretrig = '0;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_all_zero("reset", 1'b1);

        // Immediate trigger, no pre-trigger, vld held high.
        gen_clear();
        for (int i = 0; i < 2100; i++) gen_push(DW'($urandom), DW'($urandom), 1'b0, 0);
        run_capture("d1", 2'd0, '0, 0, -1, 1'b0, -1);
        chk("d1_trig_addr_const", 32'(sts_trig_addr), 0);
        chk("d1_write_count", 32'(wr_cnt), 2048);

        // Rising level on a ramp, plus an ignored arm in WAIT_TRIG.
        gen_clear();
        for (int i = 0; i < 2451; i++) gen_push(DW'(i - 500), DW'($urandom), 1'b0, 0);
        run_capture("d2", 2'd1, '0, 100, -1, 1'b0, 300);
        chk("d2_trig_addr_const", 32'(sts_trig_addr), 500);
        chk("d2_last_addr", 32'(last_wr_addr), 399);
        chk("d2_write_count", 32'(wr_cnt), 2448);

        // Long wait that wraps the pointer before the trigger.
        gen_clear();
        for (int i = 0; i < 3000; i++) gen_push(DW'(-1), DW'($urandom), 1'b0, 0);
        for (int i = 0; i < 2041; i++) gen_push('0, DW'($urandom), 1'b0, 0);
        run_capture("d3", 2'd1, '0, 10, -1, 1'b0, -1);
        chk("d3_trig_addr_const", 32'(sts_trig_addr), 952);
        chk("d3_wrapped_const", 32'(sts_wrapped), 1);
        chk("d3_last_addr", 32'(last_wr_addr), 941);

        // External edge inside a 3-cycle vld gap.
        gen_clear();
        for (int i = 0; i < 20; i++) gen_push(DW'($urandom), DW'($urandom), i == 8, (i == 8) ? 3 : 0);
        run_capture("d4", 2'd3, '0, 5, -1, 1'b0, -1);
        chk("d4_trig_addr_const", 32'(sts_trig_addr), 8);

        // Arm and abort together from DONE.
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("arm_abort_busy", 32'(sts_busy), 0);
        chk("arm_abort_done", 32'(sts_done), 0);

        // Abort mid-POST with a sample in the abort cycle.
        gen_clear();
        for (int i = 0; i < 600; i++) gen_push(DW'($urandom), DW'($urandom), 1'b0, $urandom_range(0, 2));
        run_capture("d5", 2'd0, '0, 16, 500, 1'b0, -1);

        // Maximum pre-trigger: the trigger write is also the last write.
        gen_clear();
        for (int i = 0; i < 2051; i++) gen_push(DW'($urandom), DW'($urandom), 1'b0, 0);
        run_capture("d6", 2'd0, '0, DEPTH - 1, -1, 1'b0, -1);
        chk("d6_trig_addr_const", 32'(sts_trig_addr), DEPTH - 1);

        for (int r = 0; r < 5; r++) begin
            logic [1:0] m;
            logic signed [DW-1:0] lv;
            int p, v, g;
            bit pu;
            m  = 2'($urandom);
            lv = DW'(int'($urandom_range(0, 200)) - 100);
            p  = $urandom_range(0, DEPTH - 1);
            gen_clear();
            for (int i = 0; i < p + 64; i++) begin
                v  = int'(lv) + int'($urandom_range(0, 16)) - 8;
                pu = ($urandom_range(0, 15) == 0);
                g  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                gen_push((m == 2'd0) ? DW'($urandom) : DW'(v), DW'($urandom), pu, g);
            end
            run_capture($sformatf("rnd%0d", r), m, lv, p, -1, 1'b0, -1);
        end

        // Synchronous reset while waiting for a trigger that never comes.
        gen_clear();
        for (int i = 0; i < 40; i++) gen_push('0, DW'($urandom), 1'b0, 0);
        run_capture("d7", 2'd2, DW'(-2000), 3, -1, 1'b1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
Sequences a triggered snapshot of both ADC channels into a pair of 2048-deep sample buffers, with a programmable pre-trigger depth. It sits between the AD9238 input samples and the capture RAMs. CSR fields provide arm, abort, trigger mode, trigger level and pre-trigger count. CSR status fields read back busy, triggered, done, wrapped and trigger address so firmware can unroll the ring buffer.

Parameters:
AW, 11, buffer address width; DEPTH = 2**AW samples per channel.
DW, 12, ADC sample width, two's complement.

Ports:
sys_clk  in  1  system clock; all logic on rising edge.
sys_rst  in  1  synchronous reset, active-high.
cfg_arm  in  1  single-cycle pulse; starts a capture.
cfg_abort  in  1  single-cycle pulse; cancels a capture.
cfg_trig_mode  in  2  0 immediate, 1 rising level, 2 falling level, 3 external edge.
cfg_trig_level  in  DW  signed level threshold for ch0.
cfg_pretrig  in  AW  number of samples to retain before the trigger.
ext_trig  in  1  external trigger, already synchronous to sys_clk.
adc_vld  in  1  sample strobe; may be held high or gapped.
adc_ch0  in  DW  channel 0 sample; trigger source.
adc_ch1  in  DW  channel 1 sample.
buf_wr  out  1  buffer write enable, shared by both channels.
buf_addr  out  AW  buffer write address.
buf_data0  out  DW  channel 0 write data.
buf_data1  out  DW  channel 1 write data.
sts_busy  out  1  high in PRE, WAIT_TRIG and POST.
sts_triggered  out  1  trigger has occurred in the current capture.
sts_done  out  1  capture complete; sticky until the next arm, abort or reset.
sts_wrapped  out  1  write pointer wrapped while in PRE or WAIT_TRIG.
sts_trig_addr  out  AW  buffer address of the trigger sample.

Behaviour:
- Reset: state IDLE; all outputs 0; write pointer, counters and the previous-sample register cleared.
- States: IDLE, PRE, WAIT_TRIG, POST, DONE.
- Arm:
  - Accepted only in IDLE or DONE; ignored while busy.
  - On accept: latch mode, level and pretrig; clear pointer, counters and all sts_* bits.
  - Next state is PRE, or WAIT_TRIG if pretrig == 0.
- Abort:
  - From any state, IDLE on the next cycle.
  - buf_wr is 0 from that cycle on; sts_done, sts_triggered and sts_wrapped are cleared.
  - Abort and arm in the same cycle: abort wins.
- Write path:
  - In PRE, WAIT_TRIG and POST, each adc_vld causes one write.
  - buf_wr, buf_addr and buf_data0/1 are registered, one cycle after adc_vld.
  - The pointer increments modulo DEPTH after each write.
  - No writes occur in IDLE or DONE.
- PRE: counts writes; moves to WAIT_TRIG once pretrig writes have been issued. Trigger detection is disabled in PRE.
- WAIT_TRIG: evaluates every adc_vld sample against the latched mode.
  - Mode 0: the first sample in WAIT_TRIG is the trigger.
  - Mode 1: prev < level and cur >= level, signed compare.
  - Mode 2: prev > level and cur <= level, signed compare.
  - Mode 3: a 0->1 edge of ext_trig was seen since the last vld; the next vld sample is the trigger. The edge is registered and cleared on that vld.
  - prev is the last vld ch0 sample since arm. Level modes cannot fire on the first sample after arm.
- On trigger:
  - The trigger sample is written; sts_trig_addr = its address; sts_triggered = 1.
  - Go to POST with remaining = DEPTH - pretrig - 1 further writes.
  - If remaining == 0 (pretrig = DEPTH-1), go directly to DONE.
- Wrap: a pointer wrap from DEPTH-1 to 0 in PRE or WAIT_TRIG sets sts_wrapped. A wrap in POST does not set it.
- POST: after the last write is issued, go to DONE; sts_done = 1 in the same cycle as that final buf_wr.
- Capture size: total writes after the trigger, including the trigger sample, is exactly DEPTH - pretrig.
- Widths: post counter is AW+1 bits; arithmetic is unsigned modulo DEPTH.
- Gaps in adc_vld stall all counters; they never cause spurious writes.

Test Plan:
- Mode 0, pretrig 0, adc_vld held high for 2100 cycles -> exactly 2048 writes at addr 0..2047. Then sts_done=1, sts_trig_addr=0, sts_wrapped=0, buf_wr=0.
- Mode 1, level 0, pretrig 100, ch0 ramp from -500 step +1 -> PRE ends after 100 writes. Trigger on sample value 0 (index 500), sts_trig_addr=500, 1948 writes from the trigger, last addr 399, done.
- Mode 1, level 0, pretrig 10, ch0 held at -1 for 3000 samples then 0 -> sts_wrapped=1, sts_trig_addr=952, last write addr 941, 2038 writes from the trigger.
- Mode 3, pretrig 5, ext_trig pulse between vlds with a 3-cycle vld gap -> trigger is the first vld after the pulse; no writes occur during the gap.
- Abort pulse mid-POST -> buf_wr=0 next cycle, state IDLE, all sts_*=0. A re-arm then starts again at addr 0.
- Arm pulse while busy is ignored with no counter reset; arm and abort in the same cycle -> IDLE. A sys_rst pulse mid-WAIT_TRIG -> all outputs 0 next cycle.
